mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, 16, max data-memory wait cycles before abort (range 2..255).
REQ-002 SHALL have port: clk  in  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have ports: EX_valid in 1; EX_RegWrite in 1; EX_mem_to_reg in 1; EX_MemRead in 1; EX_MemWrite in 1 (EX-stage instruction and its control).
REQ-005 SHALL have ports: EX_size in 2 (0 byte, 1 half, 2 word); EX_unsigned in 1 (zero-extend loads); EX_C in 32 (ALU result/address); EX_B in 32 (store data); EX_writereg_num in 5.
REQ-006 SHALL have ports: stall out 1 (hold EX and earlier stages); MEM_valid out 1; MEM_RegWrite out 1; MEM_mem_to_reg out 1; MEM_C out 32; MEM_read out 32; MEM_writereg_num out 5 (feed the WB pipeline register).
REQ-007 SHALL have data-memory ports: dm_req out 1; dm_we out 1; dm_addr out 32 (word-aligned); dm_be out 4; dm_wdata out 32; dm_ack in 1; dm_rdata in 32.
REQ-008 SHALL have error ports: bus_err out 1; align_err out 1 (one-cycle pulses).

Function
REQ-009 SHALL implement FSM IDLE, ACCESS; stall=1 exactly while in ACCESS or when entering it.
REQ-010 In IDLE with EX_valid=1 and neither EX_MemRead nor EX_MemWrite, SHALL register EX controls/EX_C into MEM_* next edge, MEM_valid=1, MEM_read=0 (latency 1).
REQ-011 In IDLE with EX_valid=1 and EX_MemRead or EX_MemWrite, SHALL latch the instruction, go to ACCESS, assert stall combinationally that cycle, drive dm_req=1 from next edge.
REQ-012 In ACCESS dm_req, dm_we, dm_addr, dm_be, dm_wdata SHALL stay constant until the dm_ack edge.
REQ-013 Lane rules (little-endian, lane=addr[1:0]): byte be=0001<<lane, wdata=byte x4; half be=0011<<(addr[1]*2), wdata=half x2; word be=1111; dm_addr={addr[31:2],2'b00}.
REQ-014 Load SHALL extract the addressed byte/half from dm_rdata and sign-extend, or zero-extend when EX_unsigned=1; word passes unchanged.
REQ-015 On dm_ack in ACCESS SHALL next edge: return IDLE, drop dm_req, MEM_valid=1, MEM_read=extracted data (0 for stores), MEM_* = latched controls.
REQ-016 If ACK_TIMEOUT ACCESS cycles elapse without dm_ack SHALL drop dm_req, pulse bus_err, complete with MEM_RegWrite=0, MEM_read=0; dm_ack on the timeout cycle SHALL win (normal completion).
REQ-017 In every cycle not completing an instruction SHALL output a bubble: MEM_valid=0, MEM_RegWrite=0.
REQ-018 EX_MemRead and EX_MemWrite both 1 SHALL be treated as store only.

Reset
REQ-019 rst=0 SHALL immediately force IDLE, timeout counter 0, and all outputs 0 (stall, dm_req, MEM_*, errors), regardless of in-flight access.
REQ-020 First edge after rst release SHALL behave as IDLE; an access aborted by reset SHALL not be retried.

Configuration
REQ-021 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no dm_req, pulse align_err, complete in 1 cycle with MEM_RegWrite=0.
REQ-022 Macro undefined: misaligned low address bits SHALL be ignored per REQ-013 lanes, align_err tied 0.

Structure
REQ-023 Package mem_stage_pkg SHALL hold size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the FSM state type.
REQ-024 Combinational sub-module mem_lane_align SHALL implement REQ-013/REQ-014 steering and extension.

Verification
REQ-025 ALU op EX_C=0x1234, RegWrite=1, rd=5 -> next cycle MEM_valid=1, MEM_C=0x1234, MEM_writereg_num=5, stall never 1.
REQ-026 lb addr 0x103, dm_rdata=0x80_00_00_00, ack after 3 cycles -> dm_be irrelevant, MEM_read=0xFFFFFF80; lbu -> 0x00000080; stall high 4 cycles.
REQ-027 sh addr 0x102 data 0xABCD -> dm_addr=0x100, dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1, MEM_RegWrite=0.
REQ-028 Load with no dm_ack -> bus_err pulses after 16 ACCESS cycles, dm_req=0, MEM_RegWrite=0, stall releases.
REQ-029 rst=0 mid-ACCESS -> dm_req and stall 0 same cycle, all MEM_* 0.
REQ-030 With MEM_ALIGN_CHECK_EN, lw addr 0x101 -> align_err=1, no dm_req; without macro -> dm_addr=0x100, dm_be=1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   SZ_BYTE/SZ_HALF/SZ_WORD : EX_size encodings
//   mem_state_e             : MEM-stage FSM state type
//   is_misaligned()         : alignment test, used only when MEM_ALIGN_CHECK_EN is defined
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Any size other than byte/half is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        if (size == SZ_BYTE)
            mis = 1'b0;
        else if (size == SZ_HALF)
            mis = lo[0];
        else
            mis = (lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane steering.
//   Store side: st_size/st_lane/st_data -> st_be (byte enables), st_wdata (replicated data)
//   Load side : ld_size/ld_lane/ld_unsigned/ld_rdata -> ld_data (extracted, sign/zero-extended)
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                // Only addr[1] picks the half; addr[0] is ignored.
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        ld_data = ld_rdata;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a stalling data-memory handshake.
//   clk, rst (async, active-low)
//   EX_*        : instruction and controls from the EX stage
//   stall       : holds EX and earlier stages while an access is outstanding
//   MEM_*       : registered result for the WB pipeline register
//   dm_*        : data-memory request/acknowledge interface
//   bus_err     : one-cycle pulse when an access times out (ACK_TIMEOUT cycles)
//   align_err   : one-cycle pulse on a misaligned access (MEM_ALIGN_CHECK_EN only)
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
//
// state     | meaning
// ST_IDLE   | accept one EX instruction per cycle; ALU ops complete next edge
// ST_ACCESS | data-memory request outstanding; waits for dm_ack or timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_valid,
    input  logic        EX_RegWrite,
    input  logic        EX_mem_to_reg,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [1:0]  EX_size,
    input  logic        EX_unsigned,
    input  logic [31:0] EX_C,
    input  logic [31:0] EX_B,
    input  logic [4:0]  EX_writereg_num,
    output logic        stall,
    output logic        MEM_valid,
    output logic        MEM_RegWrite,
    output logic        MEM_mem_to_reg,
    output logic [31:0] MEM_C,
    output logic [31:0] MEM_read,
    output logic [4:0]  MEM_writereg_num,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        bus_err,
    output logic        align_err
);

    // Down-counter loaded on entry; reaching zero with no ack is the timeout.
    localparam logic [7:0] TO_LOAD = 8'(ACK_TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        inst_rw_q, inst_rw_d, inst_m2r_q, inst_m2r_d, inst_load_q, inst_load_d;
    logic        inst_uns_q, inst_uns_d;
    logic [1:0]  inst_size_q, inst_size_d, inst_lane_q, inst_lane_d;
    logic [31:0] inst_c_q, inst_c_d;
    logic [4:0]  inst_rd_q, inst_rd_d;
    logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic        mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d, mem_m2r_q, mem_m2r_d;
    logic [31:0] mem_c_q, mem_c_d, mem_read_q, mem_read_d;
    logic [4:0]  mem_rd_q, mem_rd_d;
    logic        bus_err_q, bus_err_d, align_err_q, align_err_d;
    logic        stall_c, is_mem, misal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    mem_lane_align u_lane (
        .st_size     (EX_size),
        .st_lane     (EX_C[1:0]),
        .st_data     (EX_B),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_size     (inst_size_q),
        .ld_lane     (inst_lane_q),
        .ld_unsigned (inst_uns_q),
        .ld_rdata    (dm_rdata),
        .ld_data     (ld_data)
    );

    assign is_mem = EX_MemRead | EX_MemWrite;
`ifdef MEM_ALIGN_CHECK_EN
    assign misal = is_misaligned(EX_size, EX_C[1:0]);
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inst_rw_d   = inst_rw_q;
        inst_m2r_d  = inst_m2r_q;
        inst_load_d = inst_load_q;
        inst_uns_d  = inst_uns_q;
        inst_size_d = inst_size_q;
        inst_lane_d = inst_lane_q;
        inst_c_d    = inst_c_q;
        inst_rd_d   = inst_rd_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        mem_valid_d = 1'b0;
        mem_rw_d    = 1'b0;
        mem_m2r_d   = 1'b0;
        mem_c_d     = '0;
        mem_read_d  = '0;
        mem_rd_d    = '0;
        bus_err_d   = 1'b0;
        align_err_d = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (EX_valid && is_mem && !misal) begin
                    stall_c     = 1'b1;
                    state_d     = ST_ACCESS;
                    cnt_d       = TO_LOAD;
                    inst_rw_d   = EX_RegWrite;
                    inst_m2r_d  = EX_mem_to_reg;
                    // Read+write together is a store.
                    inst_load_d = ~EX_MemWrite;
                    inst_uns_d  = EX_unsigned;
                    inst_size_d = EX_size;
                    inst_lane_d = EX_C[1:0];
                    inst_c_d    = EX_C;
                    inst_rd_d   = EX_writereg_num;
                    dm_req_d    = 1'b1;
                    dm_we_d     = EX_MemWrite;
                    dm_addr_d   = {EX_C[31:2], 2'b00};
                    dm_be_d     = st_be;
                    dm_wdata_d  = st_wdata;
                end else if (EX_valid) begin
                    // ALU op, or a rejected misaligned access.
                    mem_valid_d = 1'b1;
                    mem_rw_d    = EX_RegWrite & ~is_mem;
                    mem_m2r_d   = EX_mem_to_reg;
                    mem_c_d     = EX_C;
                    mem_rd_d    = EX_writereg_num;
                    align_err_d = is_mem;
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (dm_ack || (cnt_q == '0)) begin
                    state_d     = ST_IDLE;
                    dm_req_d    = 1'b0;
                    dm_we_d     = 1'b0;
                    dm_addr_d   = '0;
                    dm_be_d     = '0;
                    dm_wdata_d  = '0;
                    mem_valid_d = 1'b1;
                    mem_m2r_d   = inst_m2r_q;
                    mem_c_d     = inst_c_q;
                    mem_rd_d    = inst_rd_q;
                    // An ack on the timeout cycle still completes normally.
                    if (dm_ack) begin
                        mem_rw_d   = inst_rw_q;
                        mem_read_d = inst_load_q ? ld_data : 32'd0;
                    end else begin
                        bus_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inst_rw_q   <= 1'b0;
            inst_m2r_q  <= 1'b0;
            inst_load_q <= 1'b0;
            inst_uns_q  <= 1'b0;
            inst_size_q <= '0;
            inst_lane_q <= '0;
            inst_c_q    <= '0;
            inst_rd_q   <= '0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= '0;
            dm_wdata_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_m2r_q   <= 1'b0;
            mem_c_q     <= '0;
            mem_read_q  <= '0;
            mem_rd_q    <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst_rw_q   <= inst_rw_d;
            inst_m2r_q  <= inst_m2r_d;
            inst_load_q <= inst_load_d;
            inst_uns_q  <= inst_uns_d;
            inst_size_q <= inst_size_d;
            inst_lane_q <= inst_lane_d;
            inst_c_q    <= inst_c_d;
            inst_rd_q   <= inst_rd_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_m2r_q   <= mem_m2r_d;
            mem_c_q     <= mem_c_d;
            mem_read_q  <= mem_read_d;
            mem_rd_q    <= mem_rd_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    // The entry-cycle stall is combinational from EX inputs, so gate it with reset.
    assign stall            = stall_c & rst;
    assign MEM_valid        = mem_valid_q;
    assign MEM_RegWrite     = mem_rw_q;
    assign MEM_mem_to_reg   = mem_m2r_q;
    assign MEM_C            = mem_c_q;
    assign MEM_read         = mem_read_q;
    assign MEM_writereg_num = mem_rd_q;
    assign dm_req           = dm_req_q;
    assign dm_we            = dm_we_q;
    assign dm_addr          = dm_addr_q;
    assign dm_be            = dm_be_q;
    assign dm_wdata         = dm_wdata_q;
    assign bus_err          = bus_err_q;
    assign align_err        = align_err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid, EX_RegWrite, EX_mem_to_reg, EX_MemRead, EX_MemWrite, EX_unsigned;
    logic [1:0]  EX_size;
    logic [31:0] EX_C, EX_B;
    logic [4:0]  EX_writereg_num;
    logic        stall, MEM_valid, MEM_RegWrite, MEM_mem_to_reg;
    logic [31:0] MEM_C, MEM_read;
    logic [4:0]  MEM_writereg_num;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        bus_err, align_err;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .EX_valid(EX_valid), .EX_RegWrite(EX_RegWrite), .EX_mem_to_reg(EX_mem_to_reg),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_size(EX_size),
        .EX_unsigned(EX_unsigned), .EX_C(EX_C), .EX_B(EX_B), .EX_writereg_num(EX_writereg_num),
        .stall(stall), .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite),
        .MEM_mem_to_reg(MEM_mem_to_reg), .MEM_C(MEM_C), .MEM_read(MEM_read),
        .MEM_writereg_num(MEM_writereg_num), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .bus_err(bus_err), .align_err(align_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        stall, valid, rw, m2r, req, we, buserr, alignerr;
        logic [31:0] c, read, addr, wdata;
        logic [4:0]  rd;
        logic [3:0]  be;
        int          kind;   // 0 bubble, 1 full result, 2 timeout result
    } exp_t;

    typedef struct {
        logic        v, rw, m2r, mr, mw, u;
        logic [1:0]  sz;
        logic [31:0] c, b;
        logic [4:0]  rd;
    } instr_t;

    function automatic exp_t zero_exp();
        exp_t z;
        z.stall = 0; z.valid = 0; z.rw = 0; z.m2r = 0; z.req = 0; z.we = 0;
        z.buserr = 0; z.alignerr = 0; z.c = 0; z.read = 0; z.addr = 0; z.wdata = 0;
        z.rd = 0; z.be = 0; z.kind = 0;
        return z;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int first_byte(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a[1:0]);
        return lo - (lo % nbytes(sz));
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int st = first_byte(sz, a);
        int n  = nbytes(sz);
        for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] rdata);
        int n = nbytes(sz);
        logic [31:0] val, mask;
        val = rdata >> (8 * first_byte(sz, a));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            val  = val & mask;
            if (!u && val[8*n-1]) val = val | ~mask;
        end
        return val;
    endfunction

    function automatic logic m_misaligned(input instr_t x);
`ifdef MEM_ALIGN_CHECK_EN
        return (int'(x.c[1:0]) % nbytes(x.sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    exp_t   e, nxt;
    logic   chk_en = 0;
    bit     busy = 0;
    int     acc_cnt, ack_at;
    instr_t acc;
    bit          force_rd = 0;
    logic [31:0] force_rd_val = 0;

    // observations for the literal pins
    int          obs_stall_cnt;
    bit          obs_req_seen, obs_buserr, obs_align;
    logic [31:0] obs_c, obs_read, obs_addr, obs_wdata;
    logic [4:0]  obs_rd;
    logic [3:0]  obs_be;
    logic        obs_rw, obs_we;

    task automatic clr_obs();
        obs_stall_cnt = 0; obs_req_seen = 0; obs_buserr = 0; obs_align = 0;
        obs_c = 'x; obs_read = 'x; obs_addr = 'x; obs_wdata = 'x; obs_rd = 'x;
        obs_be = 'x; obs_rw = 'x; obs_we = 'x;
    endtask

    // one compare process, every cycle, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, e.stall);
            chk("dm_req", dm_req, e.req);
            if (e.req) begin
                chk("dm_we", dm_we, e.we);
                chk("dm_addr", dm_addr, e.addr);
                if (e.we) begin
                    chk("dm_be", dm_be, e.be);
                    chk("dm_wdata", dm_wdata, e.wdata);
                end
            end
            chk("MEM_valid", MEM_valid, e.valid);
            chk("MEM_RegWrite", MEM_RegWrite, e.rw);
            chk("bus_err", bus_err, e.buserr);
            chk("align_err", align_err, e.alignerr);
            if (e.kind == 1) begin
                chk("MEM_C", MEM_C, e.c);
                chk("MEM_read", MEM_read, e.read);
                chk("MEM_writereg_num", MEM_writereg_num, e.rd);
                chk("MEM_mem_to_reg", MEM_mem_to_reg, e.m2r);
            end else if (e.kind == 2) begin
                chk("MEM_read_timeout", MEM_read, 32'd0);
            end
            if (stall) obs_stall_cnt++;
            if (dm_req) begin
                obs_req_seen = 1; obs_addr = dm_addr; obs_be = dm_be;
                obs_wdata = dm_wdata; obs_we = dm_we;
            end
            if (MEM_valid) begin
                obs_c = MEM_C; obs_read = MEM_read; obs_rd = MEM_writereg_num; obs_rw = MEM_RegWrite;
            end
            if (bus_err) obs_buserr = 1;
            if (align_err) obs_align = 1;
        end
    end

    // Drive one cycle (called just after a rising edge) and advance the model.
    task automatic drive(input instr_t x, input int dly, input bit rst_now);
        bit mem;
        e = nxt;
        EX_valid = x.v; EX_RegWrite = x.rw; EX_mem_to_reg = x.m2r; EX_MemRead = x.mr;
        EX_MemWrite = x.mw; EX_size = x.sz; EX_unsigned = x.u; EX_C = x.c; EX_B = x.b;
        EX_writereg_num = x.rd;
        dm_rdata = force_rd ? force_rd_val : $urandom;
        dm_ack = 0;
        nxt = zero_exp();
        if (rst_now) begin
            rst = 0;
            e = zero_exp();
            e.kind = 1;
            nxt.kind = 1;
            busy = 0;
        end else begin
            rst = 1;
            e.stall = 0;
            if (busy) begin
                e.stall = 1;
                acc_cnt++;
                if (acc_cnt == ack_at) begin
                    dm_ack = 1;
                    busy = 0;
                    nxt.kind = 1; nxt.valid = 1; nxt.rw = acc.rw; nxt.m2r = acc.m2r;
                    nxt.c = acc.c; nxt.rd = acc.rd;
                    nxt.read = (acc.mr && !acc.mw) ? m_load(acc.sz, acc.u, acc.c, dm_rdata) : 32'd0;
                end else if (acc_cnt == T) begin
                    busy = 0;
                    nxt.kind = 2; nxt.valid = 1; nxt.buserr = 1;
                end else begin
                    nxt.req = 1; nxt.we = acc.mw; nxt.addr = {acc.c[31:2], 2'b00};
                    nxt.be = m_be(acc.sz, acc.c); nxt.wdata = m_wdata(acc.sz, acc.b);
                end
            end else begin
                mem = x.mr || x.mw;
                if (x.v && mem && !m_misaligned(x)) begin
                    e.stall = 1;
                    busy = 1; acc_cnt = 0; ack_at = dly; acc = x;
                    nxt.req = 1; nxt.we = x.mw; nxt.addr = {x.c[31:2], 2'b00};
                    nxt.be = m_be(x.sz, x.c); nxt.wdata = m_wdata(x.sz, x.b);
                end else if (x.v) begin
                    nxt.kind = 1; nxt.valid = 1; nxt.rw = x.rw && !mem; nxt.m2r = x.m2r;
                    nxt.c = x.c; nxt.rd = x.rd; nxt.alignerr = mem;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic v, rw, m2r, mr, mw, input logic [1:0] sz,
                                  input logic u, input logic [31:0] c, b, input logic [4:0] rd);
        instr_t x;
        x.v = v; x.rw = rw; x.m2r = m2r; x.mr = mr; x.mw = mw; x.sz = sz; x.u = u;
        x.c = c; x.b = b; x.rd = rd;
        return x;
    endfunction

    function automatic instr_t rnd_instr(input bit allow_valid);
        instr_t x;
        int op = $urandom_range(0, 3);
        x.v   = allow_valid && ($urandom_range(0, 3) != 0);
        x.rw  = 1'($urandom); x.m2r = 1'($urandom); x.u = 1'($urandom);
        x.mr  = (op == 1) || (op == 3);
        x.mw  = (op >= 2);
        x.sz  = 2'($urandom_range(0, 2));
        x.c   = $urandom; x.b = $urandom;
        x.rd  = 5'($urandom);
        return x;
    endfunction

    function automatic int rnd_delay();
        int p = $urandom_range(0, 9);
        if (p < 5) return $urandom_range(1, 4);
        if (p < 7) return T;
        if (p < 9) return $urandom_range(T - 1, T + 1);
        return 1000;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(rnd_instr(0), 0, 0);
    endtask

    initial begin
        e = zero_exp(); nxt = zero_exp();
        rst = 0;
        EX_valid = 0; EX_RegWrite = 0; EX_mem_to_reg = 0; EX_MemRead = 0; EX_MemWrite = 0;
        EX_size = 0; EX_unsigned = 0; EX_C = 0; EX_B = 0; EX_writereg_num = 0;
        dm_ack = 0; dm_rdata = 0;
        clr_obs();
        @(posedge clk);
        #1;
        chk_en = 1;
        // reset with a live memory op on EX: everything must stay 0
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h40, 0, 3), 1, 1);
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h40, 0, 3), 1, 1);

        // ALU op
        clr_obs();
        drive(mk(1, 1, 0, 0, 0, 2'd2, 0, 32'h1234, 0, 5), 0, 0);
        idle(1);
        chk("p025_MEM_C", obs_c, 32'h1234);
        chk("p025_rd", 32'(obs_rd), 32'd5);
        chk("p025_stall_cycles", obs_stall_cnt, 0);

        // lb / lbu from byte lane 3, ack on the third access cycle
        force_rd = 1; force_rd_val = 32'h8000_0000;
        clr_obs();
        drive(mk(1, 1, 1, 1, 0, 2'd0, 0, 32'h103, 0, 7), 3, 0);
        idle(5);
        chk("p026_lb_read", obs_read, 32'hFFFF_FF80);
        chk("p026_lb_stall_cycles", obs_stall_cnt, 4);
        chk("p026_lb_addr", obs_addr, 32'h100);
        clr_obs();
        drive(mk(1, 1, 1, 1, 0, 2'd0, 1, 32'h103, 0, 7), 3, 0);
        idle(5);
        chk("p026_lbu_read", obs_read, 32'h0000_0080);
        force_rd = 0;

        // sh to upper half
        clr_obs();
        drive(mk(1, 0, 0, 0, 1, 2'd1, 0, 32'h102, 32'hABCD, 0), 2, 0);
        idle(4);
        chk("p027_addr", obs_addr, 32'h100);
        chk("p027_be", 32'(obs_be), 32'hC);
        chk("p027_wdata", obs_wdata, 32'hABCD_ABCD);
        chk("p027_we", 32'(obs_we), 32'd1);
        chk("p027_regwrite", 32'(obs_rw), 32'd0);

        // read+write together is a store
        clr_obs();
        drive(mk(1, 1, 0, 1, 1, 2'd2, 0, 32'h200, 32'h5A5A_1234, 9), 1, 0);
        idle(3);
        chk("both_we", 32'(obs_we), 32'd1);
        chk("both_read", obs_read, 32'd0);

        // timeout
        clr_obs();
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h300, 0, 4), 1000, 0);
        idle(T + 3);
        chk("p028_bus_err", 32'(obs_buserr), 32'd1);
        chk("p028_regwrite", 32'(obs_rw), 32'd0);
        chk("p028_stall_cycles", obs_stall_cnt, T + 1);
        chk("p028_req_after", dm_req, 32'd0);

        // reset mid-access, no retry afterwards
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h400, 0, 4), 1000, 0);
        idle(3);
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h400, 0, 4), 0, 1);
        chk("p029_req", dm_req, 32'd0);
        chk("p029_stall", stall, 32'd0);
        chk("p029_valid", MEM_valid, 32'd0);
        clr_obs();
        idle(4);
        chk("p029_no_retry", 32'(obs_req_seen), 32'd0);

        // misaligned word
        clr_obs();
        drive(mk(1, 1, 1, 1, 0, 2'd2, 0, 32'h101, 0, 6), 2, 0);
        idle(4);
`ifdef MEM_ALIGN_CHECK_EN
        chk("p030_align_err", 32'(obs_align), 32'd1);
        chk("p030_no_req", 32'(obs_req_seen), 32'd0);
`else
        chk("p030_addr", obs_addr, 32'h100);
        chk("p030_be", 32'(obs_be), 32'hF);
        chk("p030_no_align", 32'(obs_align), 32'd0);
`endif

        // randomized traffic with occasional reset
        for (int i = 0; i < 4000; i++) begin
            drive(rnd_instr(1), rnd_delay(), $urandom_range(0, 299) == 0);
        end
        idle(T + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
